// File: rtl/adc_serial_emulator.sv
// adc_serial_emulator: responder end of the pixel ADC serial link.
// Synchronises adc_cs/adc_sclk/ccd_sh and shifts pattern words out MSB first.
//
// Ports:
//   clk_160M    in  system clock
//   rst         in  synchronous active-high reset
//   en          in  0 ignores the pins, holds the FSM idle and adc_sdo low
//   mode        in  0 ramp, 1 const, 2 line ramp, 3 alternating const/~const
//   const_val   in  constant word for modes 1 and 3
//   ccd_sh      in  CCD shift gate, a rising edge clears the line ramp
//   adc_cs      in  active-low frame select from the master
//   adc_sclk    in  serial clock from the master, idle low
//   adc_sdo     out serial data, updated on synced sclk falling edges
//   sample_out  out word latched at the start of the current/last frame
//   frame_done  out 1-cycle pulse after a complete frame
//   short_frame out 1-cycle pulse when cs is released early
//   frame_cnt   out completed frames, wrapping
module adc_serial_emulator #(
    parameter int              WIDTH     = 16,
    parameter int              SYNC_FF   = 2,
    parameter logic [WIDTH-1:0] RAMP_STEP = 1
) (
    input  logic             clk_160M,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] const_val,
    input  logic             ccd_sh,
    input  logic             adc_cs,
    input  logic             adc_sclk,
    output logic             adc_sdo,
    output logic [WIDTH-1:0] sample_out,
    output logic             frame_done,
    output logic             short_frame,
    output logic [15:0]      frame_cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_FF-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_FF-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_FF-1:0] sh_sync_q, sh_sync_d;
    logic cs_prev_q, cs_prev_d;
    logic sclk_prev_q, sclk_prev_d;
    logic sh_prev_q, sh_prev_d;

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             sdo_q, sdo_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             frame_done_q, frame_done_d;
    logic             short_frame_q, short_frame_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [WIDTH-1:0] ramp_q, ramp_d;
    logic [WIDTH-1:0] line_q, line_d;
    logic             phase_q, phase_d;

    logic cs_s, sclk_s, sh_s;
    logic cs_fall, cs_rise, sclk_fall, sh_rise;
    logic complete;
    logic [WIDTH-1:0] word_sel;

    assign cs_s   = cs_sync_q[SYNC_FF-1];
    assign sclk_s = sclk_sync_q[SYNC_FF-1];
    assign sh_s   = sh_sync_q[SYNC_FF-1];

    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign sh_rise   = ~sh_prev_q & sh_s;

    always_comb begin
        word_sel = ramp_q;
        unique case (mode)
            2'd0: word_sel = ramp_q;
            2'd1: word_sel = const_val;
            2'd2: word_sel = line_q;
            2'd3: word_sel = phase_q ? ~const_val : const_val;
        endcase
    end

    always_comb begin
        cs_sync_d     = {cs_sync_q[SYNC_FF-2:0], adc_cs};
        sclk_sync_d   = {sclk_sync_q[SYNC_FF-2:0], adc_sclk};
        sh_sync_d     = {sh_sync_q[SYNC_FF-2:0], ccd_sh};
        cs_prev_d     = cs_s;
        sclk_prev_d   = sclk_s;
        sh_prev_d     = sh_s;
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        sdo_d         = sdo_q;
        sample_d      = sample_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        ramp_d        = ramp_q;
        line_d        = line_q;
        phase_d       = phase_q;
        complete      = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            sdo_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sdo_d = 1'b0;
                    if (cs_fall) begin
                        shreg_d  = word_sel;
                        sample_d = word_sel;
                        sdo_d    = word_sel[WIDTH-1];
                        bitcnt_d = CW'(1);
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        // A last sclk fall landing with the cs rise still
                        // means every bit was presented to the master.
                        if (sclk_fall && bitcnt_q == CW'(WIDTH)) begin
                            complete = 1'b1;
                        end else begin
                            short_frame_d = 1'b1;
                        end
                        sdo_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (sclk_fall) begin
                        if (bitcnt_q == CW'(WIDTH)) begin
                            sdo_d   = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            shreg_d  = shreg_q << 1;
                            sdo_d    = shreg_q[WIDTH-2];
                            bitcnt_d = bitcnt_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    sdo_d = 1'b0;
                    if (cs_rise) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    sdo_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (complete) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            unique case (mode)
                2'd0: ramp_d  = ramp_q + RAMP_STEP;
                2'd1: ramp_d  = ramp_q;
                2'd2: line_d  = line_q + WIDTH'(1);
                2'd3: phase_d = ~phase_q;
            endcase
        end

        // Placed after the advance so a coincident clear wins.
        if (en && sh_rise) begin
            line_d = '0;
        end
    end

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            cs_sync_q     <= '1;
            sclk_sync_q   <= '0;
            sh_sync_q     <= '0;
            cs_prev_q     <= 1'b1;
            sclk_prev_q   <= 1'b0;
            sh_prev_q     <= 1'b0;
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            sdo_q         <= 1'b0;
            sample_q      <= '0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
            frame_cnt_q   <= '0;
            ramp_q        <= '0;
            line_q        <= '0;
            phase_q       <= 1'b0;
        end else begin
            cs_sync_q     <= cs_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            sh_sync_q     <= sh_sync_d;
            cs_prev_q     <= cs_prev_d;
            sclk_prev_q   <= sclk_prev_d;
            sh_prev_q     <= sh_prev_d;
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            sdo_q         <= sdo_d;
            sample_q      <= sample_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
            frame_cnt_q   <= frame_cnt_d;
            ramp_q        <= ramp_d;
            line_q        <= line_d;
            phase_q       <= phase_d;
        end
    end

    assign adc_sdo     = sdo_q;
    assign sample_out  = sample_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
